dphy_lane_rx: RTL and testbench
===============================

# dphy_lane_rx

Single D-PHY data-lane receiver for the camera-input path. Samples the lane's dp/dn pair once per bit clock and tracks LP states through the HS entry sequence (LP-11 → LP-01 → LP-00). It locks on the SoT sync byte, then deserializes HS bits LSB-first into bytes. It reports SoT, EoT and errors to the downstream packet parser, which owns trail-byte removal.

## Interface
Parameters:
- SYNC_BYTE, 8'hB8, SoT sync pattern, LSB received first
- SETTLE_CYC, 4, minimum LP-00 (HS-prepare) samples before sync search is armed; range 1..255
- SYNC_TIMEOUT, 64, maximum bit samples in sync search before SoT error; range 9..1023

Ports:
- clk_i  in  1  bit-rate sample clock; dp/dn sampled on rising edge
- rstn_i  in  1  asynchronous, active-low reset
- dp_i  in  1  lane positive line, pre-synchronized
- dn_i  in  1  lane negative line, pre-synchronized
- byte_o  out  8  received HS byte, bit 0 = first bit on the wire
- byte_vld_o  out  1  one-cycle strobe; byte_o valid
- sot_o  out  1  one-cycle strobe; sync byte matched
- eot_o  out  1  one-cycle strobe; burst ended by LP-11
- eot_bits_o  out  3  count of trailing bits discarded at EoT; valid with eot_o
- err_o  out  1  one-cycle strobe; SoT timeout or illegal line state
- hs_active_o  out  1  high in SYNC and DATA states

## Operation
- Line states: 11 = LP-11/stop; 00 = LP-00; 01 or 10 are read as HS bits, with bit value dp_i.
- WAIT_STOP (reset state): holds until a 11 sample, then moves to STOP. A burst already in progress at reset release is ignored.
- STOP: on 01 → RQST; 11 stays; 00 or 10 → err_o, WAIT_STOP.
- RQST: on 00 → PREP, with prep counter cleared to 1; 01 stays; 11 → STOP; 10 → err_o, WAIT_STOP.
- PREP: while 00, the prep counter increments and saturates at 255. On a non-00 sample:
  - count ≥ SETTLE_CYC → SYNC; the sample is the first sync bit.
  - count < SETTLE_CYC → err_o, WAIT_STOP.
  - 11 in PREP → STOP with no error.
- SYNC: each sample shifts dp_i into the MSB of an 8-bit shift register, shifting right, and increments a bit counter.
  - Once ≥8 bits have been shifted and the register equals SYNC_BYTE → sot_o, DATA, bit counter cleared.
  - Counter reaches SYNC_TIMEOUT without a match → err_o, WAIT_STOP.
  - 11 → err_o, STOP.
  - 00 → err_o, WAIT_STOP.
- DATA: each HS sample shifts in LSB-first; a 3-bit counter wraps 7→0. On the 8th bit, byte_o loads the assembled byte and byte_vld_o pulses.
  - 11 → eot_o, eot_bits_o = bits held in the partial byte (0..7, discarded), STOP.
  - 00 → err_o, WAIT_STOP; the partial byte is discarded.
- Trail bits are delivered as ordinary bytes; the receiver does no trail detection.

## Timing
- Reset values: byte_o=0, byte_vld_o=0, sot_o=0, eot_o=0, eot_bits_o=0, err_o=0, hs_active_o=0, state=WAIT_STOP.
- All outputs are registered.
- sot_o is high the cycle after the last sync bit is sampled. The first data bit may be sampled in that same cycle.
- byte_vld_o is high the cycle after the 8th bit of a byte. Back-to-back bytes give one strobe every 8 cycles.
- byte_o holds its value until the next strobe.
- eot_o and eot_bits_o are valid the cycle after the 11 sample.
- If a byte completes on the sample just before the 11, byte_vld_o precedes eot_o by exactly one cycle, and eot_bits_o=0.
- sot_o, eot_o, err_o and byte_vld_o are never high in the same cycle.
- hs_active_o goes high the cycle after entering SYNC. It goes low the cycle after leaving DATA or SYNC.
- rstn_i is asynchronous mid-burst: it clears all state immediately, and the receiver resumes only after a fresh 11 sample.

## Configuration
- DPHY_RX_SYNC_TOLERANT_EN defined: SYNC also matches when the shift register differs from SYNC_BYTE in exactly one bit (Hamming distance 1). sot_o behaves as normal, and err_o pulses together with sot_o to flag the corrected SoT error; this is the single permitted coincidence.
- Not defined: exact match only; a 1-bit-corrupted sync is treated as a non-match and runs to timeout.

## Test plan
- Clean burst: 11, 01, 00×4, sync B8, data 01 A5 FF, then 11 → sot_o once; byte_vld_o ×3 with 01, A5, FF; eot_o with eot_bits_o=0; err_o never.
- Trail and partial byte: data 3C, then 5 trail bits, then 11 → one byte 3C, eot_bits_o=5.
- Short prepare: 00×2 with SETTLE_CYC=4, then HS bits → err_o once, no sot_o; recovers on the next clean burst.
- Sync timeout: after a valid prepare, 64 zero bits → err_o at the 64th bit, no sot_o.
- Corrupted sync B9: without the macro → timeout err_o only; with DPHY_RX_SYNC_TOLERANT_EN → sot_o together with err_o, then correct data bytes.
- Reset after 3 data bits of a byte → no outputs; the bits left in that burst are ignored until 11; the next burst decodes correctly.

Source files
------------

// File: rtl/dphy_lane_rx_if.sv
// Lane-side and parser-side signals of one D-PHY data-lane receiver.
// The master modport drives the lane and observes the decoded stream.
// The slave modport is the receiver: it samples the lane and reports bytes and events.
interface dphy_lane_rx_if;
  logic       dp_i;
  logic       dn_i;
  logic [7:0] byte_o;
  logic       byte_vld_o;
  logic       sot_o;
  logic       eot_o;
  logic [2:0] eot_bits_o;
  logic       err_o;
  logic       hs_active_o;

  modport master (
    output dp_i, dn_i,
    input  byte_o, byte_vld_o, sot_o, eot_o, eot_bits_o, err_o, hs_active_o
  );

  modport slave (
    input  dp_i, dn_i,
    output byte_o, byte_vld_o, sot_o, eot_o, eot_bits_o, err_o, hs_active_o
  );
endinterface

// File: rtl/dphy_lane_rx.sv
// Single D-PHY data-lane receiver.
// It follows the LP entry sequence LP-11 -> LP-01 -> LP-00 and searches for the SoT sync byte.
// After sync it deserializes HS bits LSB-first into bytes.
// It reports SoT, EoT and errors as one-cycle registered strobes.
// Optional feature: define DPHY_RX_SYNC_TOLERANT_EN to accept a sync byte with a single-bit error.
// A sync byte accepted this way is flagged by err_o pulsing together with sot_o.
module dphy_lane_rx #(
  parameter logic [7:0]  SYNC_BYTE    = 8'hB8,
  parameter int unsigned SETTLE_CYC   = 4,
  parameter int unsigned SYNC_TIMEOUT = 64
) (
  input logic           clk_i,
  input logic           rstn_i,
  dphy_lane_rx_if.slave lane
);

  typedef enum logic [2:0] {
    WAIT_STOP,
    STOP,
    RQST,
    PREP,
    SYNC,
    DATA
  } state_e;

  localparam logic [1:0] LINE_01    = 2'b01;
  localparam logic [1:0] LINE_10    = 2'b10;
  localparam logic [7:0] SettleThr  = SETTLE_CYC[7:0];
  localparam logic [9:0] TimeoutThr = SYNC_TIMEOUT[9:0];

  state_e     state_q;
  logic [7:0] prepCnt_q;
  logic [7:0] shiftReg_q;
  logic [9:0] bitCnt_q;
  logic [7:0] byte_q;
  logic       byteVld_q;
  logic       sot_q;
  logic       eot_q;
  logic [2:0] eotBits_q;
  logic       err_q;
  logic       hsActive_q;

  logic [1:0] line;
  logic       lineStop;
  logic       lineLp00;
  logic [7:0] shiftReg_d;
  logic [9:0] syncCnt_d;
  logic [2:0] dataCnt_d;
  logic       syncMatch;
  logic       syncCorrected;

  assign line       = {lane.dp_i, lane.dn_i};
  assign lineStop   = (line == 2'b11);
  assign lineLp00   = (line == 2'b00);
  assign shiftReg_d = {lane.dp_i, shiftReg_q[7:1]};
  assign syncCnt_d  = bitCnt_q + 10'd1;
  assign dataCnt_d  = bitCnt_q[2:0] + 3'd1;

`ifdef DPHY_RX_SYNC_TOLERANT_EN
  logic [7:0] syncDiff;
  assign syncDiff      = shiftReg_d ^ SYNC_BYTE;
  assign syncMatch     = ($countones(syncDiff) <= 1);
  assign syncCorrected = ($countones(syncDiff) == 1);
`else
  assign syncMatch     = (shiftReg_d == SYNC_BYTE);
  assign syncCorrected = 1'b0;
`endif

  // Lane state machine with registered strobes; hs_active tracks the state being entered.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= WAIT_STOP;
      prepCnt_q  <= '0;
      shiftReg_q <= '0;
      bitCnt_q   <= '0;
      byte_q     <= '0;
      byteVld_q  <= 1'b0;
      sot_q      <= 1'b0;
      eot_q      <= 1'b0;
      eotBits_q  <= '0;
      err_q      <= 1'b0;
      hsActive_q <= 1'b0;
    end else begin
      byteVld_q  <= 1'b0;
      sot_q      <= 1'b0;
      eot_q      <= 1'b0;
      err_q      <= 1'b0;
      hsActive_q <= 1'b0;
      unique case (state_q)
        WAIT_STOP: begin
          if (lineStop) state_q <= STOP;
        end
        STOP: begin
          if (line == LINE_01) begin
            state_q <= RQST;
          end else if (!lineStop) begin
            err_q   <= 1'b1;
            state_q <= WAIT_STOP;
          end
        end
        RQST: begin
          if (lineLp00) begin
            state_q   <= PREP;
            prepCnt_q <= 8'd1;
          end else if (lineStop) begin
            state_q <= STOP;
          end else if (line == LINE_10) begin
            err_q   <= 1'b1;
            state_q <= WAIT_STOP;
          end
        end
        PREP: begin
          if (lineLp00) begin
            if (prepCnt_q != 8'hFF) prepCnt_q <= prepCnt_q + 8'd1;
          end else if (lineStop) begin
            state_q <= STOP;
          end else if (prepCnt_q >= SettleThr) begin
            state_q    <= SYNC;
            shiftReg_q <= shiftReg_d;
            bitCnt_q   <= 10'd1;
            hsActive_q <= 1'b1;
          end else begin
            err_q   <= 1'b1;
            state_q <= WAIT_STOP;
          end
        end
        SYNC: begin
          if (lineStop) begin
            err_q   <= 1'b1;
            state_q <= STOP;
          end else if (lineLp00) begin
            err_q   <= 1'b1;
            state_q <= WAIT_STOP;
          end else begin
            shiftReg_q <= shiftReg_d;
            bitCnt_q   <= syncCnt_d;
            if ((syncCnt_d >= 10'd8) && syncMatch) begin
              sot_q      <= 1'b1;
              err_q      <= syncCorrected;
              state_q    <= DATA;
              bitCnt_q   <= '0;
              hsActive_q <= 1'b1;
            end else if (syncCnt_d >= TimeoutThr) begin
              err_q   <= 1'b1;
              state_q <= WAIT_STOP;
            end else begin
              hsActive_q <= 1'b1;
            end
          end
        end
        DATA: begin
          if (lineStop) begin
            eot_q     <= 1'b1;
            eotBits_q <= bitCnt_q[2:0];
            state_q   <= STOP;
          end else if (lineLp00) begin
            err_q   <= 1'b1;
            state_q <= WAIT_STOP;
          end else begin
            shiftReg_q <= shiftReg_d;
            bitCnt_q   <= {7'd0, dataCnt_d};
            hsActive_q <= 1'b1;
            if (bitCnt_q[2:0] == 3'd7) begin
              byte_q    <= shiftReg_d;
              byteVld_q <= 1'b1;
            end
          end
        end
        default: state_q <= WAIT_STOP;
      endcase
    end
  end

  assign lane.byte_o      = byte_q;
  assign lane.byte_vld_o  = byteVld_q;
  assign lane.sot_o       = sot_q;
  assign lane.eot_o       = eot_q;
  assign lane.eot_bits_o  = eotBits_q;
  assign lane.err_o       = err_q;
  assign lane.hs_active_o = hsActive_q;

endmodule

// File: tb/tb_dphy_lane_rx.sv
// Directed testbench for dphy_lane_rx.
// Each scenario task drives lane samples and compares the outputs with hand-computed values.
module tb_dphy_lane_rx;

  logic clk_i = 1'b0;
  logic rstn_i;

  dphy_lane_rx_if lane();

  dphy_lane_rx #(
    .SYNC_BYTE   (8'hB8),
    .SETTLE_CYC  (4),
    .SYNC_TIMEOUT(64)
  ) dut (
    .clk_i (clk_i),
    .rstn_i(rstn_i),
    .lane  (lane)
  );

  // Bit-rate sample clock
  always #5 clk_i = ~clk_i;

  int nChecks = 0;
  int nFails  = 0;
  int cycleCnt = 0;
  int sotCnt, eotCnt, errCnt, vldCnt, coincCnt;
  int sotCycle, eotCycle;
  int vldCycles[$];
  logic [7:0] rxBytes[$];

  task automatic clearStats();
    sotCnt = 0; eotCnt = 0; errCnt = 0; vldCnt = 0; coincCnt = 0;
    sotCycle = -1; eotCycle = -1;
    vldCycles.delete();
    rxBytes.delete();
  endtask

  // Drive one lane sample, let the DUT clock it, then tally the strobes it produced
  task automatic applyStimulus(input logic [1:0] ln);
    int s;
    @(negedge clk_i);
    lane.dp_i = ln[1];
    lane.dn_i = ln[0];
    @(posedge clk_i);
    #1;
    cycleCnt++;
    s = 0;
    if (lane.sot_o === 1'b1) begin sotCnt++; sotCycle = cycleCnt; s++; end
    if (lane.eot_o === 1'b1) begin eotCnt++; eotCycle = cycleCnt; s++; end
    if (lane.err_o === 1'b1) begin errCnt++; s++; end
    if (lane.byte_vld_o === 1'b1) begin
      vldCnt++; vldCycles.push_back(cycleCnt); rxBytes.push_back(lane.byte_o); s++;
    end
`ifdef DPHY_RX_SYNC_TOLERANT_EN
    if (s > 1 && !(s == 2 && lane.sot_o === 1'b1 && lane.err_o === 1'b1)) coincCnt++;
`else
    if (s > 1) coincCnt++;
`endif
  endtask

  task automatic sendBit(input logic b);
    applyStimulus(b ? 2'b10 : 2'b01);
  endtask

  task automatic sendByte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) sendBit(b[i]);
  endtask

  task automatic sendPrefix(input int nPrep);
    applyStimulus(2'b11);
    applyStimulus(2'b01);
    repeat (nPrep) applyStimulus(2'b00);
  endtask

  task automatic test_reset();
    rstn_i = 1'b1;
    lane.dp_i = 1'b0;
    lane.dn_i = 1'b1;
    #1 rstn_i = 1'b0;
    #2;
    nChecks++; if (lane.byte_o !== 8'h00) begin nFails++; $display("[TB] FAIL reset_byte: got %0h expected 0", lane.byte_o); end
    nChecks++; if (lane.byte_vld_o !== 1'b0) begin nFails++; $display("[TB] FAIL reset_vld: got %0b expected 0", lane.byte_vld_o); end
    nChecks++; if (lane.sot_o !== 1'b0) begin nFails++; $display("[TB] FAIL reset_sot: got %0b expected 0", lane.sot_o); end
    nChecks++; if (lane.eot_o !== 1'b0) begin nFails++; $display("[TB] FAIL reset_eot: got %0b expected 0", lane.eot_o); end
    nChecks++; if (lane.eot_bits_o !== 3'd0) begin nFails++; $display("[TB] FAIL reset_eot_bits: got %0d expected 0", lane.eot_bits_o); end
    nChecks++; if (lane.err_o !== 1'b0) begin nFails++; $display("[TB] FAIL reset_err: got %0b expected 0", lane.err_o); end
    nChecks++; if (lane.hs_active_o !== 1'b0) begin nFails++; $display("[TB] FAIL reset_hs_active: got %0b expected 0", lane.hs_active_o); end
    @(negedge clk_i);
    rstn_i = 1'b1;
    // A burst already running at reset release must be ignored until LP-11
    clearStats();
    sendByte(8'h5A);
    repeat (4) applyStimulus(2'b00);
    sendByte(8'hB8);
    nChecks++; if (sotCnt !== 0) begin nFails++; $display("[TB] FAIL reset_ignore_sot: got %0d expected 0", sotCnt); end
    nChecks++; if (errCnt !== 0) begin nFails++; $display("[TB] FAIL reset_ignore_err: got %0d expected 0", errCnt); end
    nChecks++; if (lane.hs_active_o !== 1'b0) begin nFails++; $display("[TB] FAIL reset_ignore_hs: got %0b expected 0", lane.hs_active_o); end
  endtask

  task automatic test_illegal_state();
    clearStats();
    applyStimulus(2'b11);
    applyStimulus(2'b10);
    nChecks++; if (lane.err_o !== 1'b1) begin nFails++; $display("[TB] FAIL stop_10_err: got %0b expected 1", lane.err_o); end
    applyStimulus(2'b11);
    applyStimulus(2'b01);
    applyStimulus(2'b10);
    nChecks++; if (lane.err_o !== 1'b1) begin nFails++; $display("[TB] FAIL rqst_10_err: got %0b expected 1", lane.err_o); end
    applyStimulus(2'b11);
    nChecks++; if (errCnt !== 2) begin nFails++; $display("[TB] FAIL illegal_err_count: got %0d expected 2", errCnt); end
  endtask

  task automatic test_clean_burst();
    clearStats();
    sendPrefix(4);
    sendBit(1'b0);
    nChecks++; if (lane.hs_active_o !== 1'b1) begin nFails++; $display("[TB] FAIL clean_hs_first_sync_bit: got %0b expected 1", lane.hs_active_o); end
    for (int i = 1; i < 8; i++) sendBit((i == 3 || i == 4 || i == 5 || i == 7) ? 1'b1 : 1'b0);
    nChecks++; if (lane.sot_o !== 1'b1) begin nFails++; $display("[TB] FAIL clean_sot: got %0b expected 1", lane.sot_o); end
    sendByte(8'h01);
    sendByte(8'hA5);
    sendByte(8'hFF);
    nChecks++; if (lane.byte_vld_o !== 1'b1) begin nFails++; $display("[TB] FAIL clean_last_vld: got %0b expected 1", lane.byte_vld_o); end
    nChecks++; if (lane.byte_o !== 8'hFF) begin nFails++; $display("[TB] FAIL clean_last_byte: got %0h expected ff", lane.byte_o); end
    applyStimulus(2'b11);
    nChecks++; if (lane.eot_o !== 1'b1) begin nFails++; $display("[TB] FAIL clean_eot: got %0b expected 1", lane.eot_o); end
    nChecks++; if (lane.eot_bits_o !== 3'd0) begin nFails++; $display("[TB] FAIL clean_eot_bits: got %0d expected 0", lane.eot_bits_o); end
    nChecks++; if (lane.hs_active_o !== 1'b0) begin nFails++; $display("[TB] FAIL clean_hs_after_eot: got %0b expected 0", lane.hs_active_o); end
    applyStimulus(2'b11);
    nChecks++; if (lane.byte_o !== 8'hFF) begin nFails++; $display("[TB] FAIL clean_byte_hold: got %0h expected ff", lane.byte_o); end
    nChecks++; if (sotCnt !== 1) begin nFails++; $display("[TB] FAIL clean_sot_count: got %0d expected 1", sotCnt); end
    nChecks++; if (eotCnt !== 1) begin nFails++; $display("[TB] FAIL clean_eot_count: got %0d expected 1", eotCnt); end
    nChecks++; if (errCnt !== 0) begin nFails++; $display("[TB] FAIL clean_err_count: got %0d expected 0", errCnt); end
    nChecks++; if (rxBytes.size() !== 3) begin nFails++; $display("[TB] FAIL clean_byte_count: got %0d expected 3", rxBytes.size()); end
    nChecks++; if (rxBytes[0] !== 8'h01) begin nFails++; $display("[TB] FAIL clean_byte0: got %0h expected 01", rxBytes[0]); end
    nChecks++; if (rxBytes[1] !== 8'hA5) begin nFails++; $display("[TB] FAIL clean_byte1: got %0h expected a5", rxBytes[1]); end
    nChecks++; if (rxBytes[2] !== 8'hFF) begin nFails++; $display("[TB] FAIL clean_byte2: got %0h expected ff", rxBytes[2]); end
    nChecks++; if (vldCycles[0] - sotCycle !== 8) begin nFails++; $display("[TB] FAIL clean_sot_to_vld: got %0d expected 8", vldCycles[0] - sotCycle); end
    nChecks++; if (vldCycles[1] - vldCycles[0] !== 8) begin nFails++; $display("[TB] FAIL b2b_gap01: got %0d expected 8", vldCycles[1] - vldCycles[0]); end
    nChecks++; if (vldCycles[2] - vldCycles[1] !== 8) begin nFails++; $display("[TB] FAIL b2b_gap12: got %0d expected 8", vldCycles[2] - vldCycles[1]); end
    nChecks++; if (eotCycle - vldCycles[2] !== 1) begin nFails++; $display("[TB] FAIL clean_vld_to_eot: got %0d expected 1", eotCycle - vldCycles[2]); end
    nChecks++; if (coincCnt !== 0) begin nFails++; $display("[TB] FAIL clean_coincidence: got %0d expected 0", coincCnt); end
  endtask

  task automatic test_trail_partial();
    clearStats();
    sendPrefix(4);
    sendByte(8'hB8);
    sendByte(8'h3C);
    sendBit(1'b1); sendBit(1'b0); sendBit(1'b1); sendBit(1'b1); sendBit(1'b0);
    applyStimulus(2'b11);
    nChecks++; if (lane.eot_o !== 1'b1) begin nFails++; $display("[TB] FAIL trail_eot: got %0b expected 1", lane.eot_o); end
    nChecks++; if (lane.eot_bits_o !== 3'd5) begin nFails++; $display("[TB] FAIL trail_eot_bits: got %0d expected 5", lane.eot_bits_o); end
    nChecks++; if (rxBytes.size() !== 1) begin nFails++; $display("[TB] FAIL trail_byte_count: got %0d expected 1", rxBytes.size()); end
    nChecks++; if (rxBytes[0] !== 8'h3C) begin nFails++; $display("[TB] FAIL trail_byte0: got %0h expected 3c", rxBytes[0]); end
    nChecks++; if (errCnt !== 0) begin nFails++; $display("[TB] FAIL trail_err_count: got %0d expected 0", errCnt); end
  endtask

  task automatic test_short_prepare();
    clearStats();
    sendPrefix(2);
    sendBit(1'b1);
    nChecks++; if (lane.err_o !== 1'b1) begin nFails++; $display("[TB] FAIL short_prep_err: got %0b expected 1", lane.err_o); end
    nChecks++; if (lane.hs_active_o !== 1'b0) begin nFails++; $display("[TB] FAIL short_prep_hs: got %0b expected 0", lane.hs_active_o); end
    sendByte(8'hB8);
    nChecks++; if (sotCnt !== 0) begin nFails++; $display("[TB] FAIL short_prep_sot: got %0d expected 0", sotCnt); end
    sendPrefix(4);
    sendByte(8'hB8);
    sendByte(8'h5A);
    applyStimulus(2'b11);
    nChecks++; if (errCnt !== 1) begin nFails++; $display("[TB] FAIL short_prep_err_count: got %0d expected 1", errCnt); end
    nChecks++; if (sotCnt !== 1) begin nFails++; $display("[TB] FAIL short_prep_recover_sot: got %0d expected 1", sotCnt); end
    nChecks++; if (rxBytes[0] !== 8'h5A) begin nFails++; $display("[TB] FAIL short_prep_recover_byte: got %0h expected 5a", rxBytes[0]); end
  endtask

  task automatic test_sync_timeout();
    clearStats();
    sendPrefix(4);
    repeat (63) sendBit(1'b0);
    nChecks++; if (lane.err_o !== 1'b0) begin nFails++; $display("[TB] FAIL timeout_early_err: got %0b expected 0", lane.err_o); end
    sendBit(1'b0);
    nChecks++; if (lane.err_o !== 1'b1) begin nFails++; $display("[TB] FAIL timeout_err: got %0b expected 1", lane.err_o); end
    nChecks++; if (lane.hs_active_o !== 1'b0) begin nFails++; $display("[TB] FAIL timeout_hs: got %0b expected 0", lane.hs_active_o); end
    applyStimulus(2'b11);
    nChecks++; if (sotCnt !== 0) begin nFails++; $display("[TB] FAIL timeout_sot_count: got %0d expected 0", sotCnt); end
    nChecks++; if (errCnt !== 1) begin nFails++; $display("[TB] FAIL timeout_err_count: got %0d expected 1", errCnt); end
  endtask

  task automatic test_corrupt_sync();
    clearStats();
    sendPrefix(4);
    sendByte(8'hB9);
`ifdef DPHY_RX_SYNC_TOLERANT_EN
    nChecks++; if (lane.sot_o !== 1'b1) begin nFails++; $display("[TB] FAIL corrupt_sot: got %0b expected 1", lane.sot_o); end
    nChecks++; if (lane.err_o !== 1'b1) begin nFails++; $display("[TB] FAIL corrupt_err: got %0b expected 1", lane.err_o); end
    sendByte(8'h0F);
    sendByte(8'h3C);
    applyStimulus(2'b11);
    nChecks++; if (lane.eot_bits_o !== 3'd0) begin nFails++; $display("[TB] FAIL corrupt_eot_bits: got %0d expected 0", lane.eot_bits_o); end
    nChecks++; if (rxBytes.size() !== 2) begin nFails++; $display("[TB] FAIL corrupt_byte_count: got %0d expected 2", rxBytes.size()); end
    nChecks++; if (rxBytes[0] !== 8'h0F) begin nFails++; $display("[TB] FAIL corrupt_byte0: got %0h expected 0f", rxBytes[0]); end
    nChecks++; if (rxBytes[1] !== 8'h3C) begin nFails++; $display("[TB] FAIL corrupt_byte1: got %0h expected 3c", rxBytes[1]); end
    nChecks++; if (sotCnt !== 1) begin nFails++; $display("[TB] FAIL corrupt_sot_count: got %0d expected 1", sotCnt); end
`else
    nChecks++; if (lane.sot_o !== 1'b0) begin nFails++; $display("[TB] FAIL corrupt_sot: got %0b expected 0", lane.sot_o); end
    repeat (55) sendBit(1'b0);
    nChecks++; if (lane.err_o !== 1'b0) begin nFails++; $display("[TB] FAIL corrupt_early_err: got %0b expected 0", lane.err_o); end
    sendBit(1'b0);
    nChecks++; if (lane.err_o !== 1'b1) begin nFails++; $display("[TB] FAIL corrupt_timeout_err: got %0b expected 1", lane.err_o); end
    applyStimulus(2'b11);
    nChecks++; if (sotCnt !== 0) begin nFails++; $display("[TB] FAIL corrupt_sot_count: got %0d expected 0", sotCnt); end
`endif
    nChecks++; if (errCnt !== 1) begin nFails++; $display("[TB] FAIL corrupt_err_count: got %0d expected 1", errCnt); end
    nChecks++; if (coincCnt !== 0) begin nFails++; $display("[TB] FAIL corrupt_coincidence: got %0d expected 0", coincCnt); end
  endtask

  task automatic test_reset_mid_burst();
    clearStats();
    sendPrefix(4);
    sendByte(8'hB8);
    sendByte(8'hC7);
    sendBit(1'b1); sendBit(1'b0); sendBit(1'b1);
    #1 rstn_i = 1'b0;
    #1;
    nChecks++; if (lane.byte_o !== 8'h00) begin nFails++; $display("[TB] FAIL midrst_byte: got %0h expected 0", lane.byte_o); end
    nChecks++; if (lane.hs_active_o !== 1'b0) begin nFails++; $display("[TB] FAIL midrst_hs: got %0b expected 0", lane.hs_active_o); end
    #1 rstn_i = 1'b1;
    clearStats();
    sendBit(1'b1); sendBit(1'b0); sendBit(1'b1); sendBit(1'b1); sendBit(1'b0);
    applyStimulus(2'b01);
    repeat (4) applyStimulus(2'b00);
    sendByte(8'hB8);
    sendByte(8'h44);
    nChecks++; if (sotCnt + eotCnt + errCnt + vldCnt !== 0) begin nFails++; $display("[TB] FAIL midrst_quiet: got %0d expected 0 strobes", sotCnt + eotCnt + errCnt + vldCnt); end
    sendPrefix(4);
    sendByte(8'hB8);
    sendByte(8'h96);
    applyStimulus(2'b11);
    nChecks++; if (lane.eot_o !== 1'b1) begin nFails++; $display("[TB] FAIL midrst_eot: got %0b expected 1", lane.eot_o); end
    nChecks++; if (sotCnt !== 1) begin nFails++; $display("[TB] FAIL midrst_sot_count: got %0d expected 1", sotCnt); end
    nChecks++; if (rxBytes.size() !== 1) begin nFails++; $display("[TB] FAIL midrst_byte_count: got %0d expected 1", rxBytes.size()); end
    nChecks++; if (rxBytes[0] !== 8'h96) begin nFails++; $display("[TB] FAIL midrst_byte0: got %0h expected 96", rxBytes[0]); end
    nChecks++; if (errCnt !== 0) begin nFails++; $display("[TB] FAIL midrst_err_count: got %0d expected 0", errCnt); end
  endtask

  // Run every scenario in order and print the summary
  initial begin
    clearStats();
    test_reset();
    test_illegal_state();
    test_clean_burst();
    test_trail_partial();
    test_short_prepare();
    test_sync_timeout();
    test_corrupt_sync();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
